// File: rtl/alu_packet_proc.sv
// rtl/alu_packet_proc.sv - packet parser: echo payload or add/sub 32-bit operands
module alu_packet_proc #(
  parameter logic [7:0] OPC_ECHO = 8'hEC,
  parameter logic [7:0] OPC_ADD  = 8'hA0,
  parameter logic [7:0] OPC_SUB  = 8'hA1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_ACC, S_SEND, S_DRAIN
  } state_t;

  state_t      state, state_next;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] cnt;
  logic [23:0] opnd;
  logic [31:0] acc;
  logic [1:0]  byte_idx;
  logic        first;
  logic        ready;
  logic        s_fire, m_fire;

  // Header decode values, valid during the LEN_HI byte.
  logic [15:0] l_full, pay;
  logic        is_echo, is_acc;
  logic [31:0] word, acc_new;

  assign l_full  = {s_axis_tdata, len_lo};
  assign pay     = l_full - 16'd4;
  assign is_echo = (opcode == OPC_ECHO) && (l_full >= 16'd4);
  assign is_acc  = ((opcode == OPC_ADD) || (opcode == OPC_SUB)) &&
                   (l_full >= 16'd8) && (l_full[1:0] == 2'b00);
  assign word    = {s_axis_tdata, opnd};
  assign acc_new = first ? word : ((opcode == OPC_SUB) ? acc - word : acc + word);

  // Ready is a function of state and output occupancy only, never of s_axis_tvalid.
  always_comb begin
    ready = 1'b0;
    case (state)
      S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_ACC, S_DRAIN: ready = 1'b1;
      S_ECHO:  ready = (cnt != 16'd0) && (!m_axis_tvalid || m_axis_tready);
      default: ready = 1'b0;
    endcase
  end

  assign s_axis_tready = ready && !rst;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = m_axis_tvalid && m_axis_tready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (s_fire) state_next = S_RSV;
      S_RSV:    if (s_fire) state_next = S_LEN_LO;
      S_LEN_LO: if (s_fire) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (s_fire) begin
          if (is_echo)             state_next = (pay == 16'd0) ? S_IDLE : S_ECHO;
          else if (is_acc)         state_next = S_ACC;
          else if (l_full > 16'd4) state_next = S_DRAIN;
          else                     state_next = S_IDLE;
        end
      end
      // Leave once the last byte is in and the output register has emptied.
      S_ECHO:  if ((cnt == 16'd0) && (!m_axis_tvalid || m_axis_tready)) state_next = S_IDLE;
      S_ACC:   if (s_fire && (cnt == 16'd1)) state_next = S_SEND;
      S_SEND:  if (m_fire && (byte_idx == 2'd3)) state_next = S_IDLE;
      S_DRAIN: if (s_fire && (cnt == 16'd1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: header capture, payload counting, accumulation and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode        <= 8'd0;
      len_lo        <= 8'd0;
      cnt           <= 16'd0;
      opnd          <= 24'd0;
      acc           <= 32'd0;
      byte_idx      <= 2'd0;
      first         <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE:   if (s_fire) opcode <= s_axis_tdata;
        S_LEN_LO: if (s_fire) len_lo <= s_axis_tdata;
        S_LEN_HI: begin
          if (s_fire) begin
            cnt      <= pay;
            byte_idx <= 2'd0;
            first    <= 1'b1;
            if (!is_echo && !is_acc) err_o <= 1'b1;
          end
        end
        S_ECHO: begin
          if (s_fire) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            cnt           <= cnt - 16'd1;
          end else if (m_fire) begin
            m_axis_tvalid <= 1'b0;
          end
        end
        S_ACC: begin
          if (s_fire) begin
            opnd     <= word[31:8];
            byte_idx <= byte_idx + 2'd1;
            cnt      <= cnt - 16'd1;
            if (byte_idx == 2'd3) begin
              acc   <= acc_new;
              first <= 1'b0;
              if (cnt == 16'd1) begin
                m_axis_tdata  <= acc_new[7:0];
                m_axis_tvalid <= 1'b1;
              end
            end
          end
        end
        // acc is shifted down so the next byte to send is always acc[15:8].
        S_SEND: begin
          if (m_fire) begin
            byte_idx     <= byte_idx + 2'd1;
            m_axis_tdata <= acc[15:8];
            acc          <= {8'd0, acc[31:8]};
            if (byte_idx == 2'd3) m_axis_tvalid <= 1'b0;
          end
        end
        S_DRAIN: if (s_fire) cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_packet_proc.md
Name: alu_packet_proc

Overview:
- Command/response engine between the uart_rx byte stream (AXI-Stream master) and the uart_tx byte stream (AXI-Stream slave) of the UART ALU.
- Parses framed packets as a 4-byte header followed by a payload.
- Packet types: echo the payload, or add/subtract 32-bit little-endian operands and return a 4-byte result.
- Malformed packets are drained with an error pulse, so framing recovers on the next packet.

Parameters:
- OPC_ECHO, 8'hEC: opcode for payload echo.
- OPC_ADD, 8'hA0: opcode for 32-bit add of all operands.
- OPC_SUB, 8'hA1: opcode for the first operand minus all following operands.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8  byte from uart_rx.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  block accepts input byte.
- m_axis_tdata  out  8  byte to uart_tx.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tready  in  1  uart_tx accepts byte.
- err_o  out  1  one-cycle pulse when a packet is rejected.

Behaviour:
- Packet format:
  - Byte0: opcode. Byte1: reserved, ignored.
  - Byte2/Byte3: total packet length L (16 bits, little-endian), including the 4 header bytes.
  - Payload count P = L-4.
- Transfers: an input byte transfers when s_tvalid && s_tready; an output byte transfers when m_tvalid && m_tready.
- Reset (async, active-high): state=IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, err_o=0, accumulator=0, counters=0.
  - The first cycle after reset deassertion is IDLE.
  - Reset mid-packet discards all partial state and emits no output.
- States and transitions:
  - IDLE, RSV, LEN_LO, LEN_HI: s_tready=1, and one header byte is accepted per transfer.
  - IDLE latches the opcode; LEN_LO/LEN_HI latch L.
  - Decision on the LEN_HI transfer, registered for the following cycle:
    - ECHO: opcode=OPC_ECHO and L>=4. If P=0, return to IDLE with no output.
    - ACC: opcode ADD/SUB, L>=8, and P%4==0.
    - Otherwise error: err_o=1 for exactly one cycle. Go to DRAIN if L>4, else IDLE.
  - ECHO: s_tready = !m_tvalid || m_tready (single output register, no bubble).
    - Each accepted byte loads m_tdata with m_tvalid=1.
    - Return to IDLE after byte P is accepted, once the output register is empty or that byte transfers.
    - Output order is identical to input order; latency is 1 cycle from input transfer to m_tvalid.
  - ACC: s_tready=1. Bytes are assembled LSB-first into a 32-bit operand.
    - On each 4th byte: the first operand loads the accumulator. Later operands are added (ADD) or subtracted (SUB).
    - Arithmetic is modulo 2^32; overflow and borrow are silently discarded.
    - After P bytes, go to SEND.
  - SEND: s_tready=0. Emit 4 bytes, accumulator LSB first.
    - m_tdata/m_tvalid stay stable until each transfer.
    - Return to IDLE after the 4th transfer.
  - DRAIN: s_tready=1. Discard P bytes with no output, then return to IDLE.
- AXI-Stream rules:
  - m_tvalid never drops without a transfer, and data is held while stalled.
  - s_tready does not depend combinationally on s_tvalid.
- Counters: 16-bit payload counter, no wrap for L up to 65535. L=0..3 is an error with no drain.
- Simultaneous events:
  - In ECHO with m_tvalid=1 and m_tready=1, a new input byte may be accepted in the same cycle; the register reloads with no gap.
  - Back-to-back packets: the IDLE opcode byte is accepted on the cycle after the previous packet's terminal transfer.

Test Plan:
- Echo: EC 00 06 00 41 42 with m_tready=1 -> output 41 42, err_o=0, back in IDLE.
- Add: A0 00 0C 00 02 00 00 00 03 00 00 00 -> output 05 00 00 00.
- Add wrap and sub:
  - A0 00 0C 00 01 00 00 00 FF FF FF FF -> output 00 00 00 00.
  - A1 00 0C 00 00 00 00 00 01 00 00 00 -> output FF FF FF FF.
- Errors:
  - A0 00 09 00 plus 5 bytes -> no output, one err_o pulse, 5 bytes drained.
  - Opcode 55 00 05 00 plus 1 byte -> same rejection behaviour.
  - A following EC 00 05 00 7E -> output 7E.
- Backpressure: echo of 8 payload bytes 00..07 with m_tready toggling randomly -> output exactly 00..07, no drop or duplicate, m_tdata stable while stalled.
- Reset mid-packet: assert rst after A0 00 0C 00 01 -> all outputs 0 immediately; after release, EC 00 05 00 AA -> output AA.
